// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC sequencer with redirect priority, busy-deferred redirects and bimodal BHT
`timescale 1ns/1ps
module fetch_pc_ctrl #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int                  BHT_IDX  = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                F_stall_i,
  input  logic                F_imem_busy_i,
  input  logic                F_is_branch_i,
  input  logic [PC_WIDTH-1:0] F_imm_i,
  input  logic                DD_train_vaild_i,
  input  logic                DD_train_taken_i,
  input  logic                DD_pred_taken_i,
  input  logic [PC_WIDTH-1:0] DD_train_PC_i,
  input  logic                DD_op_jalr_i,
  input  logic [PC_WIDTH-1:0] DD_jmp_i,
  input  logic                MD_need_CSR_i,
  input  logic [PC_WIDTH-1:0] MD_nPC_i,
  output logic [PC_WIDTH-1:0] F_PC_o,
  output logic                F_pred_taken_o,
  output logic                F_flush_o
);

  localparam int BHT_N = 1 << BHT_IDX;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_t;

  pend_state_t         r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pending_pc;
  logic [1:0]          r_bht [BHT_N];

  logic                w_mispredict;
  logic                w_redir_vld;
  logic [PC_WIDTH-1:0] w_redir_pc;
  logic [BHT_IDX-1:0]  w_rd_idx;
  logic [BHT_IDX-1:0]  w_wr_idx;
  logic [1:0]          w_wr_ctr;
  logic                w_unused_train_pc_bits;

  assign w_rd_idx = r_pc[BHT_IDX+1:2];
  assign w_wr_idx = DD_train_PC_i[BHT_IDX+1:2];
  assign w_wr_ctr = r_bht[w_wr_idx];
  assign w_unused_train_pc_bits = ^{DD_train_PC_i[PC_WIDTH-1:BHT_IDX+2], DD_train_PC_i[1:0]};

  assign w_mispredict = DD_train_vaild_i & (DD_train_taken_i != DD_pred_taken_i);

  // CSR/trap redirect outranks any decode-stage redirect.
  always_comb begin
    w_redir_vld = 1'b0;
    w_redir_pc  = '0;
    if (MD_need_CSR_i) begin
      w_redir_vld = 1'b1;
      w_redir_pc  = MD_nPC_i;
    end else if (w_mispredict | DD_op_jalr_i) begin
      w_redir_vld = 1'b1;
      w_redir_pc  = DD_jmp_i;
    end
  end

  assign F_PC_o         = r_pc;
  assign F_pred_taken_o = r_bht[w_rd_idx][1] & F_is_branch_i;
  assign F_flush_o      = w_redir_vld & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_pending_pc <= '0;
    end else if (F_imem_busy_i) begin
      // PC must stay stable; remember the latest redirect for later.
      if (w_redir_vld) begin
        r_state      <= PEND;
        r_pending_pc <= w_redir_pc;
      end
    end else begin
      r_state <= IDLE;
      if (w_redir_vld) begin
        r_pc <= w_redir_pc;
      end else if (r_state == PEND) begin
        r_pc <= r_pending_pc;
      end else if (F_stall_i) begin
        r_pc <= r_pc;
      end else if (F_pred_taken_o) begin
        r_pc <= r_pc + F_imm_i;
      end else begin
        r_pc <= r_pc + PC_WIDTH'(4);
      end
    end
  end

  // Training ignores stall/busy/redirect; a same-index fetch read sees the old counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (DD_train_vaild_i) begin
      if (DD_train_taken_i) begin
        if (w_wr_ctr != 2'b11) r_bht[w_wr_idx] <= w_wr_ctr + 2'b01;
      end else begin
        if (w_wr_ctr != 2'b00) r_bht[w_wr_idx] <= w_wr_ctr - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - scoreboard bench for fetch_pc_ctrl with directed vectors
`timescale 1ns/1ps
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall_i, F_imem_busy_i, F_is_branch_i;
  logic [31:0] F_imm_i;
  logic        DD_train_vaild_i, DD_train_taken_i, DD_pred_taken_i;
  logic [31:0] DD_train_PC_i;
  logic        DD_op_jalr_i;
  logic [31:0] DD_jmp_i;
  logic        MD_need_CSR_i;
  logic [31:0] MD_nPC_i;
  logic [31:0] F_PC_o;
  logic        F_pred_taken_o, F_flush_o;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        flush;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  bit   summarised = 1'b0;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .F_stall_i        (F_stall_i),
    .F_imem_busy_i    (F_imem_busy_i),
    .F_is_branch_i    (F_is_branch_i),
    .F_imm_i          (F_imm_i),
    .DD_train_vaild_i (DD_train_vaild_i),
    .DD_train_taken_i (DD_train_taken_i),
    .DD_pred_taken_i  (DD_pred_taken_i),
    .DD_train_PC_i    (DD_train_PC_i),
    .DD_op_jalr_i     (DD_op_jalr_i),
    .DD_jmp_i         (DD_jmp_i),
    .MD_need_CSR_i    (MD_need_CSR_i),
    .MD_nPC_i         (MD_nPC_i),
    .F_PC_o           (F_PC_o),
    .F_pred_taken_o   (F_pred_taken_o),
    .F_flush_o        (F_flush_o)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (F_PC_o !== mon_e.pc || F_pred_taken_o !== mon_e.pred || F_flush_o !== mon_e.flush) begin
        errors++;
        $display("FAIL %s: got pc=%h pred=%b flush=%b, expected pc=%h pred=%b flush=%b",
                 mon_e.nm, F_PC_o, F_pred_taken_o, F_flush_o, mon_e.pc, mon_e.pred, mon_e.flush);
      end
    end else if (done && !summarised) begin
      summarised = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic idle();
    F_stall_i = 0; F_imem_busy_i = 0; F_is_branch_i = 0; F_imm_i = '0;
    DD_train_vaild_i = 0; DD_train_taken_i = 0; DD_pred_taken_i = 0; DD_train_PC_i = '0;
    DD_op_jalr_i = 0; DD_jmp_i = '0; MD_need_CSR_i = 0; MD_nPC_i = '0;
  endtask

  task automatic cyc(input logic [31:0] pc, input logic pr, input logic fl, input string nm);
    exp_t e;
    e.pc = pc; e.pred = pr; e.flush = fl; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    F_is_branch_i = 1; MD_need_CSR_i = 1; MD_nPC_i = 32'h123; DD_op_jalr_i = 1;
    cyc(32'h8000_0000, 0, 0, "reset_hold");
    idle();
    cyc(32'h8000_0000, 0, 0, "reset_idle");
    rst = 1'b0;

    cyc(32'h8000_0000, 0, 0, "seq0");
    cyc(32'h8000_0004, 0, 0, "seq1");
    cyc(32'h8000_0008, 0, 0, "seq2");

    DD_train_vaild_i = 1; DD_train_taken_i = 1; DD_pred_taken_i = 1; DD_train_PC_i = 32'h8000_0010;
    cyc(32'h8000_000C, 0, 0, "train1");
    F_stall_i = 1; F_is_branch_i = 1;
    cyc(32'h8000_0010, 1, 0, "train2_stall");
    idle(); F_is_branch_i = 1; F_imm_i = 32'h40;
    cyc(32'h8000_0010, 1, 0, "pred_taken");

    idle();
    DD_train_vaild_i = 1; DD_train_taken_i = 0; DD_pred_taken_i = 1;
    DD_train_PC_i = 32'h8000_0010; DD_jmp_i = 32'h8000_0014;
    cyc(32'h8000_0050, 0, 1, "mispredict");
    idle(); DD_op_jalr_i = 1; DD_jmp_i = 32'h8000_0010;
    cyc(32'h8000_0014, 0, 1, "jalr");
    idle(); F_stall_i = 1; F_is_branch_i = 1;
    DD_train_vaild_i = 1; DD_train_taken_i = 0; DD_pred_taken_i = 0; DD_train_PC_i = 32'h8000_0010;
    cyc(32'h8000_0010, 1, 0, "rd_old_ctr");
    DD_train_vaild_i = 0;
    cyc(32'h8000_0010, 0, 0, "ctr_dec");

    MD_need_CSR_i = 1; MD_nPC_i = 32'h8000_0100; DD_op_jalr_i = 1; DD_jmp_i = 32'h8000_0200;
    cyc(32'h8000_0010, 0, 1, "csr_wins");
    idle();
    cyc(32'h8000_0100, 0, 0, "csr_target");

    F_imem_busy_i = 1; DD_op_jalr_i = 1; DD_jmp_i = 32'h1000;
    cyc(32'h8000_0104, 0, 1, "busy1");
    DD_jmp_i = 32'h2000;
    cyc(32'h8000_0104, 0, 1, "busy2");
    DD_op_jalr_i = 0;
    cyc(32'h8000_0104, 0, 0, "busy3");
    F_imem_busy_i = 0;
    cyc(32'h8000_0104, 0, 0, "busy_drop");
    cyc(32'h0000_2000, 0, 0, "pending_applied");
    F_imem_busy_i = 1; DD_op_jalr_i = 1; DD_jmp_i = 32'h3000;
    cyc(32'h0000_2004, 0, 1, "busy_redir");
    idle(); MD_need_CSR_i = 1; MD_nPC_i = 32'h4000;
    cyc(32'h0000_2004, 0, 1, "fresh_wins");
    idle();
    cyc(32'h0000_4000, 0, 0, "fresh_target");
    cyc(32'h0000_4004, 0, 0, "pend_cleared");

    DD_op_jalr_i = 1; DD_jmp_i = 32'h8000_0020;
    DD_train_vaild_i = 1; DD_train_taken_i = 0; DD_pred_taken_i = 0; DD_train_PC_i = 32'h8000_0020;
    cyc(32'h0000_4008, 0, 1, "jalr_sat");
    DD_op_jalr_i = 0; F_stall_i = 1; F_is_branch_i = 1;
    for (int i = 0; i < 4; i++) cyc(32'h8000_0020, 0, 0, "sat_nt");
    DD_train_taken_i = 1; DD_pred_taken_i = 1;
    cyc(32'h8000_0020, 0, 0, "sat_up1");
    cyc(32'h8000_0020, 0, 0, "sat_up2");
    DD_train_vaild_i = 0;
    cyc(32'h8000_0020, 1, 0, "sat_up_done");

    idle(); F_imem_busy_i = 1; DD_op_jalr_i = 1; DD_jmp_i = 32'h5000;
    cyc(32'h8000_0020, 0, 1, "busy_pend");
    #2;
    rst = 1'b1; F_imem_busy_i = 0; F_is_branch_i = 1;
    cyc(32'h8000_0000, 0, 0, "async_rst");
    rst = 1'b0;
    idle();
    cyc(32'h8000_0000, 0, 0, "rst_no_pend");
    cyc(32'h8000_0004, 0, 0, "rst_seq");
    DD_op_jalr_i = 1; DD_jmp_i = 32'h8000_0020;
    cyc(32'h8000_0008, 0, 1, "jalr_post_rst");
    idle(); F_is_branch_i = 1; F_stall_i = 1;
    cyc(32'h8000_0020, 0, 0, "bht_reset");
    checks++;
    if (F_PC_o !== 32'h8000_0020) begin
        errors++;
        $display("FAIL stall_hold_pc: got pc=%h expected 80000020", F_PC_o);
    end
    checks++;
    if (F_pred_taken_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_pred: got pred=%b expected 0", F_pred_taken_o);
    end
    checks++;
    if (F_flush_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_flush: got flush=%b expected 0", F_flush_o);
    end
    done = 1'b1;
  end

endmodule
